inst_fetch_bridge: RTL and testbench

//  Instruction-side memory bridge directly upstream of the CPU core.
//  - Takes the core's 32-bit fetch address and returns a 32-bit instruction word.
//  - Reads the word from a 16-bit external async SRAM as two halfword accesses, each with programmable wait states.
//  - Asserts a stall toward the pipeline while a fetch is in flight.
//  - Keeps a one-entry buffer, so a repeated address (a held PC) is served with no SRAM traffic.

---
 rtl/inst_fetch_bridge.sv | 108 ++++++++++
 tb/tb_inst_fetch_bridge.sv | 139 +++++++++++++
 2 files changed

// File: rtl/inst_fetch_bridge.sv
// Instruction fetch bridge: assembles a 32-bit word from two 16-bit async SRAM reads.
// A one-word buffer serves a held PC with no SRAM traffic.
module inst_fetch_bridge #(
    parameter int WAIT_CYCLES = 1,
    parameter int SRAM_AW     = 20
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               romEnable_i,
    input  logic [31:0]        romAddr_i,
    output logic [31:0]        romData_o,
    output logic               stall_o,
    output logic [SRAM_AW-1:0] sramAddr_o,
    output logic               sramCe_n_o,
    output logic               sramOe_n_o,
    input  logic [15:0]        sramData_i
);

    localparam int WAW = SRAM_AW - 1;
    localparam int CW  = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] WAIT_LD = CW'(WAIT_CYCLES);

    typedef enum logic [1:0] {IDLE, RD_LO, RD_HI} state_t;

    state_t         state;
    logic [WAW-1:0] req_addr;
    logic [WAW-1:0] buf_addr;
    logic [31:0]    buf_data;
    logic           buf_valid;
    logic [15:0]    lo_half;
    logic [CW-1:0]  wait_cnt;

    logic [WAW-1:0] wa;
    logic           hit;

    // Upper address bits alias onto the SRAM; byte offset is irrelevant.
    assign wa  = romAddr_i[SRAM_AW:2];
    assign hit = buf_valid && (buf_addr == wa);

    logic unused_addr_bits;
    assign unused_addr_bits = ^{romAddr_i[31:SRAM_AW+1], romAddr_i[1:0]};

    assign romData_o = romEnable_i ? buf_data : 32'h0;
    assign stall_o   = romEnable_i && !hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            req_addr   <= '0;
            buf_addr   <= '0;
            buf_data   <= '0;
            buf_valid  <= 1'b0;
            lo_half    <= '0;
            wait_cnt   <= '0;
            sramAddr_o <= '0;
            sramCe_n_o <= 1'b1;
            sramOe_n_o <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    sramCe_n_o <= 1'b1;
                    sramOe_n_o <= 1'b1;
                    if (romEnable_i && !hit) begin
                        req_addr   <= wa;
                        wait_cnt   <= WAIT_LD;
                        sramAddr_o <= {wa, 1'b0};
                        sramCe_n_o <= 1'b0;
                        sramOe_n_o <= 1'b0;
                        state      <= RD_LO;
                    end
                end
                RD_LO, RD_HI: begin
                    if (!romEnable_i || hit) begin
                        state      <= IDLE;
                        sramCe_n_o <= 1'b1;
                        sramOe_n_o <= 1'b1;
                    end else if (wa != req_addr) begin
                        // PC moved mid-fetch: drop the partial word and restart.
                        req_addr   <= wa;
                        wait_cnt   <= WAIT_LD;
                        sramAddr_o <= {wa, 1'b0};
                        state      <= RD_LO;
                    end else if (wait_cnt != '0) begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end else if (state == RD_LO) begin
                        lo_half    <= sramData_i;
                        wait_cnt   <= WAIT_LD;
                        sramAddr_o <= {req_addr, 1'b1};
                        state      <= RD_HI;
                    end else begin
                        buf_data   <= {sramData_i, lo_half};
                        buf_addr   <= req_addr;
                        buf_valid  <= 1'b1;
                        sramCe_n_o <= 1'b1;
                        sramOe_n_o <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state      <= IDLE;
                    sramCe_n_o <= 1'b1;
                    sramOe_n_o <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inst_fetch_bridge.sv
// Directed bench for inst_fetch_bridge with WAIT_CYCLES=1, SRAM_AW=20.
module tb_inst_fetch_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [31:0] addr;
    logic [31:0] rdata;
    logic        stall;
    logic [19:0] saddr;
    logic        ce_n, oe_n;
    logic [15:0] sdata;

    int n_chk  = 0;
    int n_pass = 0;

    inst_fetch_bridge #(.WAIT_CYCLES(1), .SRAM_AW(20)) dut (
        .clk        (clk),
        .rst        (rst),
        .romEnable_i(en),
        .romAddr_i  (addr),
        .romData_o  (rdata),
        .stall_o    (stall),
        .sramAddr_o (saddr),
        .sramCe_n_o (ce_n),
        .sramOe_n_o (oe_n),
        .sramData_i (sdata)
    );

    always #5 clk = ~clk;

    // Async SRAM model: two fixed halfwords, everything else 0xAxxx of its address.
    always_comb begin
        case (saddr)
            20'd8:   sdata = 16'h5678;
            20'd9:   sdata = 16'h1234;
            default: sdata = 16'hA000 | {4'h0, saddr[11:0]};
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Apply inputs at the falling edge; outputs are then sampled 1ns later.
    task automatic cyc(input logic e, input logic [31:0] a, input logic r);
        @(negedge clk);
        en = e; addr = a; rst = r;
        #1;
    endtask

    localparam logic [31:0] W10 = 32'h1234_5678;
    localparam logic [31:0] W24 = 32'hA013_A012;

    initial begin
        en = 1'b0; addr = '0; rst = 1'b1;
        repeat (2) @(posedge clk);
        cyc(1'b0, 32'h0, 1'b0);
        chk("rst_stall", {31'h0, stall}, 32'h0);
        chk("rst_data",  rdata, 32'h0);
        chk("rst_ce",    {31'h0, ce_n}, 32'h1);
        chk("rst_oe",    {31'h0, oe_n}, 32'h1);
        chk("rst_saddr", {12'h0, saddr}, 32'h0);

        // Miss at 0x10: stall cycles 0..4, halfword 8 then 9, data in cycle 5.
        for (int k = 0; k <= 5; k++) begin
            cyc(1'b1, 32'h10, 1'b0);
            chk($sformatf("miss_stall%0d", k), {31'h0, stall}, (k < 5) ? 32'h1 : 32'h0);
            chk($sformatf("miss_ce%0d", k), {31'h0, ce_n}, (k >= 1 && k <= 4) ? 32'h0 : 32'h1);
            if (k >= 1 && k <= 4)
                chk($sformatf("miss_saddr%0d", k), {12'h0, saddr}, (k <= 2) ? 32'd8 : 32'd9);
        end
        chk("miss_data", rdata, W10);

        // Held PC is served from the buffer.
        for (int k = 0; k < 3; k++) begin
            cyc(1'b1, 32'h10, 1'b0);
            chk($sformatf("hit_stall%0d", k), {31'h0, stall}, 32'h0);
            chk($sformatf("hit_data%0d", k), rdata, W10);
            chk($sformatf("hit_ce%0d", k), {31'h0, ce_n}, 32'h1);
        end

        // Aliased, misaligned address maps to the same word.
        cyc(1'b1, 32'h0040_0013, 1'b0);
        chk("alias_stall", {31'h0, stall}, 32'h0);
        chk("alias_data",  rdata, W10);

        // Miss at 0x20, switch to 0x24 in the first RD_HI cycle (cycle 3).
        for (int k = 0; k <= 8; k++) begin
            cyc(1'b1, (k < 3) ? 32'h20 : 32'h24, 1'b0);
            if (k < 8) chk($sformatf("abort_stall%0d", k), {31'h0, stall}, 32'h1);
            if (k == 3) chk("abort_hi_saddr", {12'h0, saddr}, 32'd17);
            if (k == 4) chk("abort_restart", {12'h0, saddr}, 32'h12);
            if (k == 6) chk("abort_hi2", {12'h0, saddr}, 32'h13);
        end
        chk("abort_stall8", {31'h0, stall}, 32'h0);
        chk("abort_data",   rdata, W24);
        cyc(1'b1, 32'h20, 1'b0);
        chk("abort_noval", {31'h0, stall}, 32'h1);

        // Disable during RD_LO.
        cyc(1'b0, 32'h20, 1'b0);
        chk("dis_data0",  rdata, 32'h0);
        chk("dis_stall0", {31'h0, stall}, 32'h0);
        cyc(1'b0, 32'h20, 1'b0);
        chk("dis_ce",    {31'h0, ce_n}, 32'h1);
        chk("dis_stall", {31'h0, stall}, 32'h0);
        chk("dis_data",  rdata, 32'h0);

        // Buffer still valid for 0x24 after the abandoned fetch.
        cyc(1'b1, 32'h24, 1'b0);
        chk("buf24_stall", {31'h0, stall}, 32'h0);
        chk("buf24_data",  rdata, W24);

        // Reset mid-fetch clears the buffer.
        cyc(1'b1, 32'h10, 1'b0);
        cyc(1'b1, 32'h10, 1'b1);
        cyc(1'b0, 32'h10, 1'b0);
        chk("mrst_ce",    {31'h0, ce_n}, 32'h1);
        chk("mrst_saddr", {12'h0, saddr}, 32'h0);
        for (int k = 0; k <= 5; k++) begin
            cyc(1'b1, 32'h24, 1'b0);
            chk($sformatf("mrst_stall%0d", k), {31'h0, stall}, (k < 5) ? 32'h1 : 32'h0);
        end
        chk("mrst_data", rdata, W24);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
